pixel_upscaler: RTL and testbench

//  Upstream pixel source for the ILI9341 SPI display path. Walks a SRC_W x SRC_H image held
//  in a synchronous-read ROM and emits an integer nearest-neighbour upscaled stream of
//  (SRC_W*SCALE) x (SRC_H*SCALE) pixels in raster order. Each pixel is delivered over a

---
 rtl/pixel_upscaler.sv | 88 ++++++++
 tb/tb_pixel_upscaler.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/pixel_upscaler.sv
// pixel_upscaler: walks a ROM image and streams a nearest-neighbour upscaled frame over valid/ready
module pixel_upscaler #(
  parameter int SRC_W      = 80,
  parameter int SRC_H      = 80,
  parameter int SCALE      = 3,
  parameter int PIXEL_SIZE = 16,
  parameter int ADDR_W     = $clog2(SRC_W*SRC_H)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic [PIXEL_SIZE-1:0] mem_data,
  output logic [PIXEL_SIZE-1:0] pixel_data,
  output logic                  pixel_valid,
  input  logic                  pixel_ready,
  output logic                  busy,
  output logic                  frame_done
);
  localparam int XW = $clog2(SRC_W+1);
  localparam int YW = $clog2(SRC_H+1);
  localparam int RW = $clog2(SCALE+1);
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, HOLD, DONE} state_t;
  state_t state, state_n;
  logic [XW-1:0] sx, sx_n;
  logic [YW-1:0] sy, sy_n;
  logic [RW-1:0] rx, rx_n, ry, ry_n;
  logic [ADDR_W-1:0] row_base, row_n;
  logic xfer, end_rx, end_x, end_y, last, can_start;
  always_comb begin
    xfer = pixel_valid && pixel_ready;
    can_start = (state == IDLE || state == DONE) && start;
    end_rx = rx == RW'(SCALE-1);
    end_x = end_rx && sx == XW'(SRC_W-1);
    end_y = end_x && ry == RW'(SCALE-1);
    last = end_y && sy == YW'(SRC_H-1);
    rx_n = end_rx ? '0 : rx + 1'b1;
    sx_n = !end_rx ? sx : end_x ? '0 : sx + 1'b1;
    ry_n = !end_x ? ry : end_y ? '0 : ry + 1'b1;
    sy_n = !end_y ? sy : last ? '0 : sy + 1'b1;
    row_n = !end_y ? row_base : last ? '0 : row_base + ADDR_W'(SRC_W);
    state_n = state;
    if (state == IDLE || state == DONE) state_n = start ? FETCH : state;
    else if (state == FETCH) state_n = LOAD;
    else if (state == LOAD) state_n = HOLD;
    else if (xfer) state_n = last ? DONE : end_rx ? FETCH : HOLD;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      sx <= '0;
      sy <= '0;
      rx <= '0;
      ry <= '0;
      row_base <= '0;
      mem_addr <= '0;
      pixel_data <= '0;
      pixel_valid <= 1'b0;
    end else begin
      state <= state_n;
      if (can_start) begin
        sx <= '0;
        sy <= '0;
        rx <= '0;
        ry <= '0;
        row_base <= '0;
        mem_addr <= '0;
      end
      if (state == LOAD) begin
        pixel_data <= mem_data;
        pixel_valid <= 1'b1;
      end
      if (state == HOLD && xfer) begin
        sx <= sx_n;
        sy <= sy_n;
        rx <= rx_n;
        ry <= ry_n;
        row_base <= row_n;
        if (end_rx) begin
          pixel_valid <= 1'b0;
          mem_addr <= row_n + ADDR_W'(sx_n);
        end
      end
    end
  end
  assign busy = !(state == IDLE || state == DONE);
  assign frame_done = state == DONE;
endmodule

// File: tb/tb_pixel_upscaler.sv
// tb_pixel_upscaler: directed vectors and frame scoreboards for pixel_upscaler
module tb_pixel_upscaler;
  logic clk = 1'b0;
  logic rst, start_a, start_b, ready, sel;
  logic [1:0] addr_a;
  logic [4:0] addr_b;
  logic [15:0] mdata_a, mdata_b, pix_a, pix_b;
  logic valid_a, valid_b, busy_a, busy_b, done_a, done_b;
  logic [15:0] rom_a [4];
  logic [15:0] rom_b [20];
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  pixel_upscaler #(.SRC_W(2), .SRC_H(2), .SCALE(3), .PIXEL_SIZE(16)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .mem_addr(addr_a), .mem_data(mdata_a),
    .pixel_data(pix_a), .pixel_valid(valid_a), .pixel_ready(ready), .busy(busy_a), .frame_done(done_a));
  pixel_upscaler #(.SRC_W(5), .SRC_H(4), .SCALE(2), .PIXEL_SIZE(16)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .mem_addr(addr_b), .mem_data(mdata_b),
    .pixel_data(pix_b), .pixel_valid(valid_b), .pixel_ready(ready), .busy(busy_b), .frame_done(done_b));
  always @(posedge clk) begin
    mdata_a <= rom_a[addr_a];
    mdata_b <= rom_b[addr_b];
  end
  wire        m_valid = sel ? valid_b : valid_a;
  wire        m_busy  = sel ? busy_b : busy_a;
  wire        m_done  = sel ? done_b : done_a;
  wire [15:0] m_data  = sel ? pix_b : pix_a;
  wire [4:0]  m_addr  = sel ? addr_b : {3'b0, addr_a};
  typedef struct {
    logic start, rdy, valid, busy, done;
    logic [15:0] data;
    logic [1:0] addr;
  } vec_t;
  vec_t tv [10];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [15:0] exp_pix(input bit s, input int n);
    int w, sc, x, y;
    w = s ? 5 : 2;
    sc = s ? 2 : 3;
    x = n % (w*sc);
    y = n / (w*sc);
    return s ? rom_b[(y/sc)*w + x/sc] : rom_a[(y/sc)*w + x/sc];
  endfunction
  task automatic pulse(input bit s);
    sel = s;
    if (s) start_b = 1'b1;
    else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
    chk("start_state", {m_done, m_busy, m_valid, 27'b0, m_addr}, {1'b0, 1'b1, 1'b0, 27'b0, 5'd0});
  endtask
  task automatic collect(input bit s, input int first, input bit rnd, input int abort_at);
    int n, cyc, total, maxa;
    bit hold, aborted;
    logic [15:0] held;
    sel = s;
    total = s ? 80 : 36;
    n = first;
    cyc = 0;
    maxa = 0;
    hold = 0;
    aborted = 0;
    held = '0;
    while (n < total && cyc < 5000 && !aborted) begin
      if (hold) chk("stable", {15'b0, m_valid, m_data}, {15'b0, 1'b1, held});
      ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start_a = rnd && !s && $urandom_range(0, 7) == 0;
      if (int'(m_addr) > maxa) maxa = int'(m_addr);
      if (m_valid && ready) begin
        chk("pixel", {16'b0, m_data}, {16'b0, exp_pix(s, n)});
        n++;
        if (n == abort_at) begin
          rst = 1'b0;
          aborted = 1;
        end
      end
      hold = m_valid && !ready;
      held = m_data;
      @(posedge clk); #1;
      cyc++;
    end
    start_a = 1'b0;
    if (aborted) begin
      chk("abort_state", {m_valid, m_busy, m_done, 24'b0, m_addr}, 32'd0);
      rst = 1'b1;
    end else begin
      chk("count", n, total);
      chk("done_rise", {m_done, m_busy, m_valid}, {1'b1, 1'b0, 1'b0});
      chk("max_addr", maxa, s ? 19 : 3);
    end
  endtask
  initial begin
    rom_a = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD};
    for (int i = 0; i < 20; i++) rom_b[i] = 16'(16'h1000 + i * 16'h0111);
    tv[0] = '{1, 0, 0, 1, 0, 16'h0000, 2'd0};
    tv[1] = '{0, 0, 0, 1, 0, 16'h0000, 2'd0};
    tv[2] = '{0, 1, 1, 1, 0, 16'hAAAA, 2'd0};
    tv[3] = '{0, 0, 1, 1, 0, 16'hAAAA, 2'd0};
    tv[4] = '{0, 1, 1, 1, 0, 16'hAAAA, 2'd0};
    tv[5] = '{0, 1, 1, 1, 0, 16'hAAAA, 2'd0};
    tv[6] = '{0, 1, 0, 1, 0, 16'hAAAA, 2'd1};
    tv[7] = '{0, 1, 0, 1, 0, 16'hAAAA, 2'd1};
    tv[8] = '{0, 1, 1, 1, 0, 16'hBBBB, 2'd1};
    tv[9] = '{1, 0, 1, 1, 0, 16'hBBBB, 2'd1};
    sel = 1'b0;
    rst = 1'b0;
    start_a = 1'b1;
    start_b = 1'b1;
    ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_a", {valid_a, busy_a, done_a, pix_a, 11'b0, addr_a}, 32'd0);
    chk("reset_b", {valid_b, busy_b, done_b, pix_b, 8'b0, addr_b}, 32'd0);
    start_a = 1'b0;
    start_b = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("idle_a", {valid_a, busy_a, done_a, pix_a, 11'b0, addr_a}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      start_a = tv[i].start;
      ready = tv[i].rdy;
      @(posedge clk); #1;
      chk($sformatf("vec%0d", i), {valid_a, busy_a, done_a, pix_a, 11'b0, addr_a},
          {tv[i].valid, tv[i].busy, tv[i].done, tv[i].data, 11'b0, tv[i].addr});
    end
    start_a = 1'b0;
    collect(0, 3, 0, -1);
    pulse(0);
    collect(0, 0, 1, -1);
    pulse(0);
    collect(0, 0, 0, -1);
    pulse(1);
    collect(1, 0, 0, -1);
    pulse(1);
    collect(1, 0, 1, 13);
    pulse(1);
    collect(1, 0, 0, -1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
